// File: rtl/lap_recorder_pkg.sv
// Shared time-field widths, radix constants and storage entry layout
// for the stopwatch lap recorder.
package lap_recorder_pkg;

    localparam int HOUR_W = 6;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CS_W   = 7;
    localparam int TIME_W = HOUR_W + MIN_W + SEC_W + CS_W;
    localparam int NUM_W  = 7;

    localparam logic [7:0]       CS_RADIX = 8'd100;
    localparam logic [6:0]       SM_RADIX = 7'd60;
    localparam logic [NUM_W-1:0] LAP_MAX  = 7'd99;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
        logic [CS_W-1:0]   csec;
    } time_t;

    typedef struct packed {
        time_t             abs_t;
        time_t             split_t;
        logic [NUM_W-1:0]  num;
    } entry_t;

endpackage

// File: rtl/lap_recorder_time_sub.sv
// Combinational mixed-radix subtractor: diff = a - b over
// centiseconds (base 100), seconds/minutes (base 60), hours (mod 64).
module time_sub
    import lap_recorder_pkg::*;
(
    input  time_t a,
    input  time_t b,
    output time_t diff
);

    logic [7:0] cs_a, cs_b, cs_r;
    logic [6:0] sc_a, sc_b, sc_r;
    logic [6:0] mn_a, mn_b, mn_r;
    logic       cs_borrow, sc_borrow, mn_borrow;

    // Each field borrows from the next when the minuend is smaller,
    // adding its radix back so the field stays in range.
    always_comb begin
        cs_a      = {1'b0, a.csec};
        cs_b      = {1'b0, b.csec};
        cs_borrow = cs_a < cs_b;
        cs_r      = cs_borrow ? (cs_a + CS_RADIX - cs_b) : (cs_a - cs_b);

        sc_a      = {1'b0, a.second};
        sc_b      = {1'b0, b.second} + {6'd0, cs_borrow};
        sc_borrow = sc_a < sc_b;
        sc_r      = sc_borrow ? (sc_a + SM_RADIX - sc_b) : (sc_a - sc_b);

        mn_a      = {1'b0, a.minute};
        mn_b      = {1'b0, b.minute} + {6'd0, sc_borrow};
        mn_borrow = mn_a < mn_b;
        mn_r      = mn_borrow ? (mn_a + SM_RADIX - mn_b) : (mn_a - mn_b);

        diff.csec   = cs_r[CS_W-1:0];
        diff.second = sc_r[SEC_W-1:0];
        diff.minute = mn_r[MIN_W-1:0];
        diff.hour   = a.hour - b.hour - {5'd0, mn_borrow};
    end

endmodule

// File: rtl/lap_recorder.sv
// Lap capture with split computation into a circular buffer of the last
// DEPTH laps, read newest-first through a registered address port.
module lap_recorder
    import lap_recorder_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lap,
    input  logic              clear,
    input  logic              run,
    input  logic [5:0]        hour,
    input  logic [5:0]        minute,
    input  logic [5:0]        second,
    input  logic [6:0]        m_sec,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [6:0]        rd_num,
    output logic [24:0]       rd_abs,
    output logic [24:0]       rd_split,
    output logic [ADDR_W:0]   lap_count,
    output logic [6:0]        lap_total,
    output logic              lap_stb
);

    localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    logic              lap_q, lap_d, clear_q, clear_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [NUM_W-1:0]  total_q, total_d;
    logic              stb_q, stb_d;
    time_t             prev_q, prev_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic              rd_valid_q, rd_valid_d;
    entry_t            rd_q, rd_d;

    logic              lap_rise, clear_rise, capture;
    time_t             cur_time, split_time;
    logic [ADDR_W-1:0] phys_idx;
    logic [NUM_W-1:0]  next_num;

    assign cur_time = '{hour: hour, minute: minute, second: second, csec: m_sec};

    time_sub u_time_sub (
        .a    (cur_time),
        .b    (prev_q),
        .diff (split_time)
    );

    always_comb begin
        lap_d      = lap;
        clear_d    = clear;
        lap_rise   = lap & ~lap_q;
        clear_rise = clear & ~clear_q;
        capture    = lap_rise & run & ~clear_rise;
        next_num   = (total_q == LAP_MAX) ? LAP_MAX : total_q + 7'd1;

        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        total_d  = total_q;
        prev_d   = prev_q;
        stb_d    = capture;
        mem_d    = mem_q;

        if (clear_rise) begin
            wr_ptr_d = '0;
            count_d  = '0;
            total_d  = '0;
            prev_d   = '0;
        end else if (capture) begin
            mem_d[wr_ptr_q] = '{abs_t: cur_time, split_t: split_time, num: next_num};
            wr_ptr_d        = wr_ptr_q + ONE;
            count_d         = (count_q == FULL) ? FULL : count_q + 1'b1;
            total_d         = next_num;
            prev_d          = cur_time;
        end
    end

    // Reads see the buffer as it stood before this cycle's write.
    always_comb begin
        phys_idx   = wr_ptr_q - ONE - rd_addr;
        rd_valid_d = {1'b0, rd_addr} < count_q;
        rd_d       = rd_valid_d ? mem_q[phys_idx] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lap_q      <= 1'b0;
            clear_q    <= 1'b0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            total_q    <= '0;
            stb_q      <= 1'b0;
            prev_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_q       <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            lap_q      <= lap_d;
            clear_q    <= clear_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            total_q    <= total_d;
            stb_q      <= stb_d;
            prev_q     <= prev_d;
            rd_valid_q <= rd_valid_d;
            rd_q       <= rd_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_num    = rd_q.num;
    assign rd_abs    = rd_q.abs_t;
    assign rd_split  = rd_q.split_t;
    assign lap_count = count_q;
    assign lap_total = total_q;
    assign lap_stb   = stb_q;

endmodule
